// File: rtl/instruction_fetch_unit_pkg.sv
// mips_pkg: shared widths, opcode field bounds and fetch state encoding
package mips_pkg;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int INSTR_WIDTH_DEF = 16;
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam logic [15:0] NOP = 16'h0000;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: memory, decode handshake and control signals of the fetch unit
interface instruction_fetch_unit_if
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic if_valid;
  logic if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [ADDR_WIDTH-1:0] if_pc_plus2;
  logic redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic resume;
  logic halted;
  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc_plus2, halted,
    input imem_instr, if_ready, redirect_valid, redirect_pc, resume
  );
  modport slave (
    input imem_addr, if_valid, if_instr, if_pc, if_pc_plus2, halted,
    output imem_instr, if_ready, redirect_valid, redirect_pc, resume
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// fetch_pc_reg: program counter with redirect > advance > hold priority
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pc
);
  logic [ADDR_WIDTH-1:0] pc_n;
  // targets are halfword aligned, so bit 0 of a redirect is dropped
  always_comb pc_n = redirect ? {redirect_pc[ADDR_WIDTH-1:1], 1'b0} : advance ? pc + ADDR_WIDTH'(2) : pc;
  // pc register
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else pc <= pc_n;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC sequencing, one-entry fetch output stage, redirect flush and halt/resume
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OPCODE = HALT_OP
) (
  input logic clk,
  input logic reset,
  instruction_fetch_unit_if.master bus
);
  fetch_state_t state, state_n;
  logic valid_n, halted_n, load, free;
  logic [ADDR_WIDTH-1:0] pc;
  fetch_pc_reg #(.ADDR_WIDTH(ADDR_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .redirect(bus.redirect_valid),
    .advance(load),
    .redirect_pc(bus.redirect_pc),
    .pc(pc)
  );
  assign bus.imem_addr = pc;
  assign free = !bus.if_valid || bus.if_ready;
  // redirect flushes first; otherwise RUN fetches into a free stage, HALTED drains then waits for resume
  always_comb begin
    state_n = state;
    valid_n = bus.if_valid;
    load = 1'b0;
    if (bus.redirect_valid) begin
      state_n = RUN;
      valid_n = 1'b0;
    end else if (state == RUN && free) begin
      load = 1'b1;
      valid_n = 1'b1;
      state_n = bus.imem_instr[OP_HI:OP_LO] == HALT_OPCODE ? HALTED : RUN;
    end else if (state == HALTED && bus.if_valid && bus.if_ready) begin
      valid_n = 1'b0;
    end else if (state == HALTED && !bus.if_valid && bus.resume) begin
      state_n = RUN;
    end
    halted_n = state_n == HALTED && !valid_n;
  end
  // control state: fsm state, stage occupancy and halted flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      bus.if_valid <= 1'b0;
      bus.halted <= 1'b0;
    end else begin
      state <= state_n;
      bus.if_valid <= valid_n;
      bus.halted <= halted_n;
    end
  // output stage payload, loaded only on a fetch
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.if_instr <= INSTR_WIDTH'(NOP);
      bus.if_pc <= '0;
      bus.if_pc_plus2 <= '0;
    end else if (load) begin
      bus.if_instr <= bus.imem_instr;
      bus.if_pc <= pc;
      bus.if_pc_plus2 <= pc + ADDR_WIDTH'(2);
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Sequences the combinational instruction memory for the simplified MIPS core. Owns the program counter, drives the memory address, and registers each fetched instruction into a one-entry output stage with a valid/ready handshake to decode. Handles branch/jump redirects with a flush, and halts on a HALT opcode until it is told to resume.

Parameters:
- ADDR_WIDTH, 16, PC and memory address width (byte address)
- INSTR_WIDTH, 16, instruction width
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- imem_addr  out  ADDR_WIDTH  address to the instruction memory; equals the current PC (combinational from the PC register)
- imem_instr  in  INSTR_WIDTH  memory data; valid in the same cycle as imem_addr
- if_valid  out  1  output stage holds an instruction
- if_ready  in  1  decode accepts the instruction this cycle
- if_instr  out  INSTR_WIDTH  registered instruction
- if_pc  out  ADDR_WIDTH  address of if_instr
- if_pc_plus2  out  ADDR_WIDTH  if_pc + 2, modulo 2^16
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  ADDR_WIDTH  target address; bit 0 is ignored and forced to 0
- resume  in  1  leave the HALTED state
- halted  out  1  fetch stopped and the halt instruction has been consumed

Behaviour:
- Decided: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: pc=RESET_PC, state=RUN, if_valid=0, if_instr=16'h0000, if_pc=0, if_pc_plus2=0, halted=0. Reset asserted mid-operation discards the held instruction immediately.
- States: RUN and HALTED.
- Stage is free when if_valid=0, or when if_valid=1 and if_ready=1.
- RUN, no redirect, stage free, at the clock edge:
  - if_instr<=imem_instr, if_pc<=pc, if_pc_plus2<=pc+2, if_valid<=1, pc<=pc+2.
  - The first instruction appears one edge after reset deasserts.
  - With if_ready held at 1, throughput is one instruction per cycle.
- Stall: if_valid=1 and if_ready=0 -> all registers hold and imem_addr stays constant.
- Redirect has highest priority, in any state:
  - pc<={redirect_pc[15:1],1'b0}, if_valid<=0. The held instruction is flushed even if if_ready=1 in the same cycle.
  - No fetch happens that cycle.
  - The target instruction is valid two edges after the redirect edge's cycle, i.e. one edge after the redirect edge.
  - In HALTED, a redirect also moves state to RUN and clears halted.
- Halt entry: when a fetch in RUN loads an instruction with imem_instr[15:12]==HALT_OPCODE:
  - That instruction is loaded normally and pc still advances by 2.
  - State goes to HALTED and no further fetches occur.
  - If a redirect arrives in the same cycle, the redirect wins, nothing is loaded, and the state stays RUN.
- HALTED:
  - The halt instruction remains presented until accepted.
  - halted=1 when state==HALTED and if_valid==0 (registered, so it updates at the edge that consumes the halt).
  - resume=1 -> state<=RUN, halted<=0; fetch restarts from pc (halt address + 2) on the next edge.
  - resume while the halt instruction is still valid is ignored.
- Wrap-around: pc=16'hFFFE advances to 16'h0000 without error, and if_pc_plus2 wraps the same way.
- Memory contents are never interpreted except for the halt opcode check.

Decomposition:
- Shared package (mips_pkg):
  - ADDR_WIDTH/INSTR_WIDTH defaults, HALT_OPCODE, NOP encoding 16'h0000, opcode field bounds [15:12].
  - Fetch state encoding: RUN=1'b0, HALTED=1'b1.
- One sub-module, fetch_pc_reg: holds the PC with an async reset and computes next-PC from the {redirect, advance, hold} priority. Output-stage and state logic stay in the top module.

Test Plan:
- Reset, if_ready=1, bench memory returns {4'h1,addr[11:0]} -> if_pc sequence 0000,0002,0004,0006 on consecutive edges, if_instr 1000,1002,1004,1006; if_valid stays 1 from the first edge.
- Hold if_ready=0 for 3 cycles at if_pc=0004 -> if_instr=1004 and imem_addr=0006 held constant; if_ready=1 then resumes with 0006 and no instruction is skipped or duplicated.
- redirect_valid=1 with redirect_pc=0x0041 while if_valid=1 and if_ready=1 -> if_valid=0 on the next cycle, then if_pc=0040, if_instr=1040; nothing from the old path appears.
- Memory returns F000 at 0008 -> F000 is presented, no fetch from 000A occurs, halted=1 after acceptance; resume=1 -> next if_pc=000A.
- Redirect to FFFC with sequential fetch -> if_pc FFFC, FFFE, 0000; if_pc_plus2 at FFFE equals 0000.
- Assert reset asynchronously mid-stall with if_valid=1 -> if_valid=0 and pc=RESET_PC immediately, before the next clock edge.
